// File: rtl/aukv_uart_pkg.sv
// Shared UART definitions: line-FSM state encoding and divider/counter sizing helpers.
package aukv_uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   // Oversample tick divider, rounded down.
   function automatic int unsigned uart_div(input int unsigned clk_freq,
                                            input int unsigned baud,
                                            input int unsigned os);
      return clk_freq / (baud * os);
   endfunction

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/aukv_sync_fifo.sv
// Generic synchronous FIFO: a push is visible at the head one cycle later.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module aukv_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_wr_vld,
   input  logic [WIDTH-1:0] i_wr_dat,
   output logic             o_full,
   output logic             o_rd_vld,
   output logic [WIDTH-1:0] o_rd_dat,
   input  logic             i_rd_rdy
);
   localparam int unsigned AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);

   logic [AW:0]      wptr_q, rptr_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             empty, rd_en, wr_en;

   // Extra MSB on each pointer distinguishes full from empty.
   assign empty    = (wptr_q == rptr_q);
   assign o_full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign o_rd_vld = !empty;
   assign o_rd_dat = mem_q[rptr_q[AW-1:0]];
   assign rd_en    = !empty && i_rd_rdy;
   assign wr_en    = i_wr_vld && (!o_full || rd_en);

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         wptr_q <= '0;
         rptr_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else begin
         if (wr_en) begin
            mem_q[wptr_q[AW-1:0]] <= i_wr_dat;
            wptr_q                <= wptr_q + 1'b1;
         end
         if (rd_en) rptr_q <= rptr_q + 1'b1;
      end
   end

endmodule

// File: rtl/aukv_uart_rx.sv
// 8N1 UART receiver with 3-sample majority vote; byte reaches o_valid one cycle after mid-stop push.
// Consumer backpressure via i_ready; bytes arriving while the FIFO is full are dropped and flagged.
module aukv_uart_rx
   import aukv_uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 50_000_000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic       i_clk,
   input  logic       i_rstn,
   input  logic       i_rx,
   output logic [7:0] o_data,
   output logic       o_valid,
   input  logic       i_ready,
   output logic       o_frame_err,
   output logic       o_overrun,
   input  logic       i_clr_err,
   output logic       o_busy
);
   localparam int unsigned DIV = uart_div(CLK_FREQ, BAUD, OVERSAMPLE);
   localparam int unsigned DW  = cnt_width(DIV);
   localparam int unsigned SW  = cnt_width(OVERSAMPLE);
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [SW-1:0] S_LO     = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] S_MID    = SW'(OVERSAMPLE / 2);
   localparam logic [SW-1:0] S_HI     = SW'(OVERSAMPLE / 2 + 1);
   localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);

   logic          rx_meta_q, rx_s_q, rx_prev_q;
   uart_state_e   state_q;
   logic [DW-1:0] div_q;
   logic [SW-1:0] samp_q;
   logic [1:0]    votes_q;
   logic          bit_q;
   logic [2:0]    idx_q;
   logic [7:0]    shreg_q;
   logic          push_vld_q;
   logic [7:0]    push_dat_q;
   logic          frame_err_q, overrun_q;
   logic          tick, vote_tick, end_tick, vote_d, fifo_full, pop;

   assign tick      = (state_q != IDLE) && (div_q == DIV_LAST);
   assign vote_tick = tick && (samp_q == S_HI);
   assign end_tick  = tick && (samp_q == S_LAST);
   assign vote_d    = (votes_q[0] & votes_q[1]) | (votes_q[0] & rx_s_q) | (votes_q[1] & rx_s_q);
   assign pop       = o_valid && i_ready;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= i_rx;
         rx_s_q    <= rx_meta_q;
         rx_prev_q <= rx_s_q;
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q     <= IDLE;
         div_q       <= '0;
         samp_q      <= '0;
         votes_q     <= '0;
         bit_q       <= 1'b0;
         idx_q       <= '0;
         shreg_q     <= '0;
         push_vld_q  <= 1'b0;
         push_dat_q  <= '0;
         frame_err_q <= 1'b0;
      end else begin
         push_vld_q <= 1'b0;
         if (i_clr_err) frame_err_q <= 1'b0;

         // Divider and sample counter restart on every start edge so sampling is phase-aligned.
         if (state_q == IDLE) begin
            div_q  <= '0;
            samp_q <= '0;
         end else if (tick) begin
            div_q  <= '0;
            samp_q <= samp_q + 1'b1;
         end else begin
            div_q <= div_q + 1'b1;
         end
         if (tick && samp_q == S_LO)  votes_q[0] <= rx_s_q;
         if (tick && samp_q == S_MID) votes_q[1] <= rx_s_q;

         case (state_q)
            IDLE: if (rx_prev_q && !rx_s_q) state_q <= START;
            START: begin
               if (vote_tick && vote_d) begin
                  state_q <= IDLE;
               end else if (end_tick) begin
                  state_q <= DATA;
                  idx_q   <= '0;
               end
            end
            DATA: begin
               if (vote_tick) bit_q <= vote_d;
               if (end_tick) begin
                  shreg_q <= {bit_q, shreg_q[7:1]};
                  idx_q   <= idx_q + 1'b1;
                  if (idx_q == 3'd7) state_q <= STOP;
               end
            end
            STOP: begin
               // Leave at mid-stop so a following start edge one bit later is not missed.
               if (vote_tick) begin
                  state_q <= IDLE;
                  if (vote_d) begin
                     push_vld_q <= 1'b1;
                     push_dat_q <= shreg_q;
                  end else begin
                     frame_err_q <= 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         overrun_q <= 1'b0;
      end else if (push_vld_q && fifo_full && !pop) begin
         overrun_q <= 1'b1;
      end else if (i_clr_err) begin
         overrun_q <= 1'b0;
      end
   end

   aukv_sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk    (i_clk),
      .i_rstn   (i_rstn),
      .i_wr_vld (push_vld_q),
      .i_wr_dat (push_dat_q),
      .o_full   (fifo_full),
      .o_rd_vld (o_valid),
      .o_rd_dat (o_data),
      .i_rd_rdy (i_ready)
   );

   assign o_frame_err = frame_err_q;
   assign o_overrun   = overrun_q;
   assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_aukv_uart_rx.sv
// Bench for aukv_uart_rx: serial frames in, FIFO output checked against a byte-queue model.
module tb_aukv_uart_rx;
   localparam int DEPTH   = 4;
   localparam int BIT_CYC = 432;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       rx = 1'b1;
   logic       ready = 1'b0;
   logic       clr = 1'b0;
   logic [7:0] data;
   logic       valid, ferr, ovr, busy;

   aukv_uart_rx #(
      .CLK_FREQ   (50_000_000),
      .BAUD       (115200),
      .OVERSAMPLE (16),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .i_clk       (clk),
      .i_rstn      (rstn),
      .i_rx        (rx),
      .o_data      (data),
      .o_valid     (valid),
      .i_ready     (ready),
      .o_frame_err (ferr),
      .o_overrun   (ovr),
      .i_clr_err   (clr),
      .o_busy      (busy)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_fail = 0;
   logic [7:0] exp_q[$];
   logic [7:0] popped[$];
   bit         exp_ferr = 1'b0;
   bit         exp_ovr = 1'b0;
   logic       valid_prev = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] popped_at(input int i);
      logic [7:0] r;
      r = 8'hxx;
      if (i < popped.size()) r = popped[i];
      return r;
   endfunction

   // Compare process: any byte the DUT presents must be the oldest byte the model expects.
   always @(negedge clk) begin
      if (!rstn) begin
         valid_prev = 1'b0;
      end else begin
         if (valid && (ready || !valid_prev)) begin
            check("valid_needs_model_byte", {31'd0, valid}, {31'd0, exp_q.size() > 0});
            if (exp_q.size() > 0) begin
               check("head_data", {24'd0, data}, {24'd0, exp_q[0]});
               if (ready) void'(exp_q.pop_front());
            end
            if (ready) popped.push_back(data);
         end
         valid_prev = valid;
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Model: a good frame is kept if the FIFO has room, else overrun; a low stop bit flags and drops.
   task automatic model_frame(input logic [7:0] b, input bit stop_ok);
      if (!stop_ok)                 exp_ferr = 1'b1;
      else if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else                          exp_ovr = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int bc);
      rx = 1'b0;
      wait_cyc(bc);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         wait_cyc(bc);
      end
      model_frame(b, stop_ok);
      rx = stop_ok;
      wait_cyc(bc);
      rx = 1'b1;
   endtask

   task automatic check_flags(input string tag);
      check({tag, "_frame_err"}, {31'd0, ferr}, {31'd0, exp_ferr});
      check({tag, "_overrun"},   {31'd0, ovr},  {31'd0, exp_ovr});
   endtask

   task automatic clear_err();
      clr = 1'b1;
      wait_cyc(1);
      clr = 1'b0;
      exp_ferr = 1'b0;
      exp_ovr  = 1'b0;
      wait_cyc(1);
   endtask

   task automatic drain(input string tag);
      ready = 1'b1;
      for (int i = 0; i < 200 && (valid || exp_q.size() > 0); i++) wait_cyc(1);
      wait_cyc(2);
      check({tag, "_drained_valid"}, {31'd0, valid}, 32'd0);
      check({tag, "_model_empty"},   exp_q.size(),   32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] bytes[5];
      int         bc;

      wait_cyc(5);
      check("reset_data",      {24'd0, data}, 32'd0);
      check("reset_valid",     {31'd0, valid}, 32'd0);
      check("reset_frame_err", {31'd0, ferr}, 32'd0);
      check("reset_overrun",   {31'd0, ovr}, 32'd0);
      check("reset_busy",      {31'd0, busy}, 32'd0);
      rstn = 1'b1;
      wait_cyc(10);

      // Single byte, consumer always ready
      ready = 1'b1;
      popped.delete();
      send_byte(8'h55, 1'b1, BIT_CYC);
      wait_cyc(20);
      check("t1_pop_count", popped.size(), 32'd1);
      check("t1_byte", {24'd0, popped_at(0)}, 32'h55);
      check_flags("t1");

      // Back-to-back burst held in the FIFO
      ready = 1'b0;
      popped.delete();
      send_byte(8'hA3, 1'b1, BIT_CYC);
      send_byte(8'h00, 1'b1, BIT_CYC);
      send_byte(8'hFF, 1'b1, BIT_CYC);
      wait_cyc(20);
      check("t2_valid_held", {31'd0, valid}, 32'd1);
      drain("t2");
      check("t2_pop0", {24'd0, popped_at(0)}, 32'hA3);
      check("t2_pop1", {24'd0, popped_at(1)}, 32'h00);
      check("t2_pop2", {24'd0, popped_at(2)}, 32'hFF);
      check("t2_pop_count", popped.size(), 32'd3);

      // Overrun: five random bytes into a four-deep FIFO
      ready = 1'b0;
      popped.delete();
      for (int i = 0; i < 5; i++) bytes[i] = 8'($urandom);
      for (int i = 0; i < 5; i++) send_byte(bytes[i], 1'b1, BIT_CYC);
      wait_cyc(20);
      check("t3_overrun_set", {31'd0, ovr}, 32'd1);
      check_flags("t3");
      clear_err();
      check("t3_overrun_cleared", {31'd0, ovr}, 32'd0);
      drain("t3");
      check("t3_pop_count", popped.size(), 32'd4);
      for (int i = 0; i < 4; i++) check("t3_kept_byte", {24'd0, popped_at(i)}, {24'd0, bytes[i]});

      // Framing error, then recovery
      ready = 1'b1;
      popped.delete();
      send_byte(8'h3C, 1'b0, BIT_CYC);
      wait_cyc(20);
      check("t4_frame_err_set", {31'd0, ferr}, 32'd1);
      check("t4_no_push", popped.size(), 32'd0);
      send_byte(8'h12, 1'b1, BIT_CYC);
      wait_cyc(20);
      check("t4_recovered_byte", {24'd0, popped_at(0)}, 32'h12);
      check_flags("t4");
      clear_err();
      check("t4_frame_err_cleared", {31'd0, ferr}, 32'd0);

      // Short low glitch on an idle line
      popped.delete();
      rx = 1'b0;
      wait_cyc(100);
      rx = 1'b1;
      wait_cyc(50);
      check("t5_busy_during_glitch", {31'd0, busy}, 32'd1);
      wait_cyc(400);
      check("t5_busy_after_glitch", {31'd0, busy}, 32'd0);
      check("t5_no_push", popped.size(), 32'd0);
      check_flags("t5");

      // Reset in the middle of the data bits
      popped.delete();
      rx = 1'b0;
      wait_cyc(BIT_CYC);
      rx = 1'b1;
      wait_cyc(BIT_CYC);
      rx = 1'b0;
      wait_cyc(BIT_CYC / 2);
      rstn = 1'b0;
      exp_q.delete();
      exp_ferr = 1'b0;
      exp_ovr  = 1'b0;
      wait_cyc(3);
      check("t6_busy_in_reset",  {31'd0, busy}, 32'd0);
      check("t6_valid_in_reset", {31'd0, valid}, 32'd0);
      rx = 1'b1;
      wait_cyc(3);
      rstn = 1'b1;
      wait_cyc(BIT_CYC);
      send_byte(8'h81, 1'b1, BIT_CYC);
      wait_cyc(20);
      check("t6_pop_count", popped.size(), 32'd1);
      check("t6_byte", {24'd0, popped_at(0)}, 32'h81);
      check_flags("t6");

      // Sender 3% fast, single random byte
      popped.delete();
      bytes[0] = 8'($urandom);
      send_byte(bytes[0], 1'b1, 419);
      wait_cyc(20);
      check("t7_fast_byte", {24'd0, popped_at(0)}, {24'd0, bytes[0]});

      // Sender 3% slow, three random back-to-back bytes held then drained
      ready = 1'b0;
      popped.delete();
      for (int i = 0; i < 3; i++) bytes[i] = 8'($urandom);
      bc = 445;
      for (int i = 0; i < 3; i++) send_byte(bytes[i], 1'b1, bc);
      wait_cyc(20);
      drain("t8");
      for (int i = 0; i < 3; i++) check("t8_slow_byte", {24'd0, popped_at(i)}, {24'd0, bytes[i]});
      check_flags("t8");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
